seek_sched: RTL and testbench
=============================

SEEK_SCHED -- requirements
Module: seek_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one seek_f unit (fixed at 4 for this revision).
REQ-002 Parameter TMO, default 15, maximum cycles spent in WAIT before the operation is aborted.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester level request.
REQ-006 req_e  input  NREQ*`Datawidth  operand bus; requester i occupies bits [i*`Datawidth +: `Datawidth].
REQ-007 gnt  output  NREQ  one-hot, one-cycle grant pulse; the winner's operand is sampled in the same cycle.
REQ-008 unit_e  output  `Datawidth  operand to the seek_f unit.
REQ-009 unit_en  output  1  enable to the seek_f unit.
REQ-010 unit_f  input  `Datawidth+3  result from the seek_f unit.
REQ-011 unit_rdy  input  1  result-valid from the seek_f unit.
REQ-012 res_valid  output  1  result available to the requester side.
REQ-013 res_ready  input  1  requester side accepts the result.
REQ-014 res_id  output  2  index of the requester that owns the result.
REQ-015 res_data  output  `Datawidth+3  captured unit_f, or zero on error.
REQ-016 res_err  output  1  result aborted by timeout.

Function
REQ-017 All outputs SHALL be registered; at most one operation SHALL be outstanding.
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE, req != 0 -> round-robin winner w; gnt[w]=1 for one cycle; latch req_e slice w and id w; next state ISSUE.
REQ-020 Round-robin: search order starts at (last+1) mod NREQ; last updates to w on every grant; last resets to NREQ-1, so requester 0 wins first.
REQ-021 ISSUE: unit_en=1 and unit_e=latched operand for exactly one cycle; clear the timeout counter; next state WAIT.
REQ-022 unit_en SHALL be 0 in every state except ISSUE; unit_e SHALL hold its last value outside ISSUE.
REQ-023 WAIT, unit_rdy=1 -> res_data<=unit_f, res_err<=0, res_valid<=1; next state RESP.
REQ-024 WAIT, unit_rdy=0 -> increment the counter; when the counter reaches TMO, set res_data<=0, res_err<=1 and res_valid<=1; next state RESP.
REQ-025 A unit_rdy arriving in the same cycle as counter==TMO SHALL take priority, giving a good result.
REQ-026 unit_rdy in IDLE, ISSUE or RESP SHALL be ignored and SHALL have no side effects.
REQ-027 RESP: hold res_valid, res_id, res_data and res_err stable until res_valid&&res_ready; on that cycle res_valid<=0 and the next state is IDLE.
REQ-028 Best-case latency: gnt at cycle 0, unit_en at cycle 1, unit_rdy at cycle 2, res_valid at cycle 3.
REQ-029 New arbitration SHALL start only in IDLE; the earliest next gnt is in the cycle after the accepting cycle.
REQ-030 req changes outside IDLE SHALL be ignored; a requester still asserting req after its gnt competes again.
REQ-031 Requests from all four requesters held continuously SHALL be served in the order 0,1,2,3,0,...
REQ-032 gnt SHALL be all-zero in every cycle except the IDLE grant cycle.

Reset
REQ-033 rst_n=0 SHALL immediately force: state=IDLE, gnt=0, unit_en=0, unit_e=0, res_valid=0, res_id=0, res_data=0, res_err=0, counter=0, last=NREQ-1.
REQ-034 Reset asserted mid-operation, in any state, SHALL abort the operation with no result delivered.
REQ-035 The first grant after release of rst_n SHALL occur no earlier than the first posedge with rst_n=1.

Verification
REQ-036 Single request: req=0001, req_e[0]=0x2005, unit_f=0x1234 with unit_rdy one cycle after unit_en -> gnt=0001 at c0, unit_en=1 and unit_e=0x2005 at c1, res_valid=1, res_id=0, res_data=0x1234 and res_err=0 at c3.
REQ-037 Fairness: req=1111 held with res_ready=1 -> grant order 0,1,2,3,0; no gnt while busy.
REQ-038 Back-pressure: res_ready=0 for 5 cycles after res_valid -> outputs stable, no gnt; res_ready=1 -> accepted, next gnt 1 cycle later.
REQ-039 Timeout: unit_rdy never asserted with TMO=15 -> res_valid=1, res_err=1 and res_data=0 after 15 WAIT cycles; late unit_rdy in RESP ignored.
REQ-040 Timeout boundary: unit_rdy in the same cycle counter==TMO -> res_err=0, res_data=unit_f.
REQ-041 Reset mid-WAIT: rst_n=0 -> all outputs reset immediately; after release, req=0100 -> gnt=0100.

Source files
------------

// File: rtl/seek_sched.sv
// Round-robin scheduler sharing one seek_f unit among NREQ requesters.
// One operation in flight: grant, issue, wait (with timeout), respond.
`ifndef Datawidth
`define Datawidth 16
`endif

module seek_sched #(
    parameter int NREQ = 4,
    parameter int TMO  = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*`Datawidth-1:0]  req_e,
    output logic [NREQ-1:0]             gnt,
    output logic [`Datawidth-1:0]       unit_e,
    output logic                        unit_en,
    input  logic [`Datawidth+2:0]       unit_f,
    input  logic                        unit_rdy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [1:0]                  res_id,
    output logic [`Datawidth+2:0]       res_data,
    output logic                        res_err
);

    localparam int DW = `Datawidth;
    localparam int RW = `Datawidth + 3;
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_d;
    logic [NREQ-1:0] gnt_d;
    logic [DW-1:0]   unit_e_d;
    logic            unit_en_d;
    logic            res_valid_d;
    logic [1:0]      res_id_d;
    logic [RW-1:0]   res_data_d;
    logic            res_err_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [1:0]      last, last_d;
    logic [DW-1:0]   op, op_d;
    logic [1:0]      id, id_d;

    logic            found;
    logic [1:0]      win;
    logic            arb_en;

    // Rotating priority search starting just after the last winner.
    always_comb begin
        logic [1:0] cand;
        cand  = '0;
        found = 1'b0;
        win   = last;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Outputs are registered, so the grant is decided on the edge entering the
    // IDLE grant cycle: either from an idle IDLE or from the accepting RESP edge.
    assign arb_en = ((state == IDLE) && (gnt == '0)) ||
                    ((state == RESP) && res_valid && res_ready);

    always_comb begin
        state_d     = state;
        gnt_d       = '0;
        unit_e_d    = unit_e;
        unit_en_d   = 1'b0;
        res_valid_d = res_valid;
        res_id_d    = res_id;
        res_data_d  = res_data;
        res_err_d   = res_err;
        cnt_d       = cnt;
        last_d      = last;
        op_d        = op;
        id_d        = id;

        case (state)
            IDLE: begin
                if (gnt != '0) begin
                    state_d   = ISSUE;
                    unit_en_d = 1'b1;
                    unit_e_d  = op;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (unit_rdy) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_id_d    = id;
                    res_data_d  = unit_f;
                    res_err_d   = 1'b0;
                end else if (cnt == CW'(TMO)) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_id_d    = id;
                    res_data_d  = '0;
                    res_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RESP: begin
                if (res_valid && res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb_en && found) begin
            gnt_d[win] = 1'b1;
            op_d       = req_e[32'(win)*DW +: DW];
            id_d       = win;
            last_d     = win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            unit_e    <= '0;
            unit_en   <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            cnt       <= '0;
            last      <= 2'(NREQ - 1);
            op        <= '0;
            id        <= '0;
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            unit_e    <= unit_e_d;
            unit_en   <= unit_en_d;
            res_valid <= res_valid_d;
            res_id    <= res_id_d;
            res_data  <= res_data_d;
            res_err   <= res_err_d;
            cnt       <= cnt_d;
            last      <= last_d;
            op        <= op_d;
            id        <= id_d;
        end
    end

endmodule

// File: tb/tb_seek_sched.sv
// Self-checking bench for seek_sched: directed scenarios plus randomized
// operations, checked against a transaction-level round-robin/timing model.
`ifndef Datawidth
`define Datawidth 16
`endif

module tb_seek_sched;

    localparam int NREQ = 4;
    localparam int TMO  = 15;
    localparam int DW   = `Datawidth;
    localparam int RW   = `Datawidth + 3;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_e;
    logic [NREQ-1:0]      gnt;
    logic [DW-1:0]        unit_e;
    logic                 unit_en;
    logic [RW-1:0]        unit_f;
    logic                 unit_rdy;
    logic                 res_valid;
    logic                 res_ready;
    logic [1:0]           res_id;
    logic [RW-1:0]        res_data;
    logic                 res_err;

    int errors = 0;
    int checks = 0;
    logic [1:0] last_m;
    int order[$];

    seek_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_e(req_e), .gnt(gnt),
        .unit_e(unit_e), .unit_en(unit_en), .unit_f(unit_f), .unit_rdy(unit_rdy),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_data(res_data), .res_err(res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Next winner: first requester found walking forward from last+1.
    function automatic logic [1:0] rr(input logic [3:0] r, input logic [1:0] last);
        for (int k = 1; k <= 4; k++)
            if (r[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
        return last;
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_unit_en"}, unit_en, 0);
        chk({tag, "_unit_e"}, unit_e, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_id"}, res_id, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_err"}, res_err, 0);
    endtask

    task automatic do_reset;
        tick;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst");
        tick;
        last_m = 2'(NREQ - 1);
        rst_n = 1'b1;
    endtask

    // One full operation. rdy_k: WAIT cycle index (0-based) carrying unit_rdy,
    // >TMO means never. set_req=0 continues a held request whose grant must
    // already be visible (one cycle after the previous accept).
    task automatic do_op(input logic [3:0] reqv, input bit set_req, input bit rand_data,
                         input int rdy_k, input bit rdy_in_issue, input int hold,
                         input bit keep_req);
        logic [1:0]    w;
        logic [DW-1:0] e_exp;
        logic [RW-1:0] f_exp;
        int            lim;
        bit            good;
        if (set_req) begin
            req = reqv;
            lim = 8;
            if (rand_data)
                for (int i = 0; i < NREQ; i++) req_e[i*DW +: DW] = DW'($urandom);
        end else begin
            lim = 0;
        end
        if (rand_data) unit_f = RW'($urandom);
        f_exp = unit_f;
        w     = rr(reqv, last_m);
        e_exp = req_e[int'(w)*DW +: DW];
        for (int i = 0; i < lim && gnt === '0; i++) tick;
        chk("gnt", gnt, 4'b0001 << w);
        order.push_back(idx_of(gnt));
        last_m = w;
        if (!keep_req) req = '0;

        tick;
        chk("unit_en_issue", unit_en, 1);
        chk("unit_e", unit_e, e_exp);
        chk("gnt_issue", gnt, 0);
        unit_rdy = rdy_in_issue;

        good = (rdy_k <= TMO);
        for (int k = 0; k <= TMO; k++) begin
            tick;
            chk("wait_valid", res_valid, 0);
            chk("wait_unit_en", unit_en, 0);
            chk("wait_gnt", gnt, 0);
            unit_rdy = (k == rdy_k);
            if (k == rdy_k) break;
        end

        tick;
        unit_rdy = 1'b0;
        chk("res_valid", res_valid, 1);
        chk("res_id", res_id, w);
        chk("res_data", res_data, good ? f_exp : '0);
        chk("res_err", res_err, !good);
        res_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            tick;
            chk("hold_valid", res_valid, 1);
            chk("hold_id", res_id, w);
            chk("hold_data", res_data, good ? f_exp : '0);
            chk("hold_err", res_err, !good);
            chk("hold_gnt", gnt, 0);
            unit_rdy  = 1'($urandom);
            unit_f    = RW'($urandom);
            res_ready = (h == hold - 1);
        end

        tick;
        unit_rdy  = 1'b0;
        res_ready = 1'b0;
        chk("accept_valid", res_valid, 0);
        if (!keep_req) chk("idle_gnt", gnt, 0);
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; req = '0; req_e = '0; unit_f = '0; unit_rdy = 1'b0; res_ready = 1'b0;
        last_m = 2'(NREQ - 1);

        // Reset state, with requests present that must not be granted.
        req = 4'b1111;
        tick; tick;
        chk_all_zero("por");
        req = '0;
        tick;
        rst_n = 1'b1;

        // Single request with fixed operand/result, best-case latency.
        req_e[0 +: DW] = DW'(16'h2005);
        unit_f = RW'(16'h1234);
        do_op(4'b0001, 1, 0, 0, 0, 0, 0);

        // Fairness from reset: all four held, accepted immediately.
        do_reset;
        order.delete();
        for (int i = 0; i < NREQ; i++) req_e[i*DW +: DW] = DW'($urandom);
        do_op(4'b1111, 1, 0, 1, 0, 0, 1);
        for (int n = 0; n < 3; n++) do_op(4'b1111, 0, 1, $urandom_range(0, 3), 0, 0, 1);
        do_op(4'b1111, 0, 1, 0, 0, 0, 0);
        for (int n = 0; n < 5; n++) chk("rr_order", order[n], exp_order[n]);

        // Back-pressure: 5 cycles stalled, next held request granted right after accept.
        do_op(4'b0011, 1, 1, 2, 0, 5, 1);
        do_op(4'b0011, 0, 1, 0, 0, 0, 0);

        // Timeout with unit_rdy only in ISSUE and late in RESP; then boundary.
        do_op(4'b1000, 1, 1, 99, 1, 2, 0);
        do_op(4'b0010, 1, 1, TMO, 0, 1, 0);

        // Randomized operations.
        for (int n = 0; n < 12; n++) begin
            int rk;
            case ($urandom_range(0, 5))
                0:       rk = TMO;
                1:       rk = 99;
                default: rk = $urandom_range(0, 6);
            endcase
            do_op(4'($urandom_range(1, 15)), 1, 1, rk, 1'($urandom), $urandom_range(0, 3), 0);
        end

        // Reset in the middle of WAIT: nothing delivered, fresh arbitration after.
        req = 4'b0001;
        for (int i = 0; i < 8 && gnt === '0; i++) tick;
        req = '0;
        tick; tick; tick;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick;
        chk("midrst_valid", res_valid, 0);
        last_m = 2'(NREQ - 1);
        rst_n = 1'b1;
        do_op(4'b0100, 1, 1, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
